// File: rtl/ahbl_2m_rr_arbiter.sv
// ---------------------------------------------------------------------------
// ahbl_2m_rr_arbiter
//
// Shares one AHB-Lite slave port between two grant-less AHB-Lite masters
// (M0 = EL2 IFU, M1 = EL2 LSU) using round-robin arbitration.
//
// Each master has a one-entry input stage. An address phase that cannot be
// forwarded in the cycle it is accepted is parked there. The master is then
// stalled through HREADY_Mx until its data phase completes.
//
// Ports
//   HCLK, HRESETn          clock, asynchronous active-low reset
//   H*_M0 / H*_M1          master-side address/control/write-data inputs,
//                          plus HREADY_Mx / HRDATA_Mx returned to each master
//   HADDR, HTRANS, HWRITE,
//   HSIZE, HWDATA          slave-side outputs
//   HRDATA, HREADY         slave-side responses (HRESP is not supported)
// ---------------------------------------------------------------------------
module ahbl_2m_rr_arbiter #(
  parameter int AW = 32,
  parameter int DW = 64
) (
  input  logic          HCLK,
  input  logic          HRESETn,
  // master 0
  input  logic [AW-1:0] HADDR_M0,
  input  logic [1:0]    HTRANS_M0,
  input  logic          HWRITE_M0,
  input  logic [2:0]    HSIZE_M0,
  input  logic [DW-1:0] HWDATA_M0,
  output logic          HREADY_M0,
  output logic [DW-1:0] HRDATA_M0,
  // master 1
  input  logic [AW-1:0] HADDR_M1,
  input  logic [1:0]    HTRANS_M1,
  input  logic          HWRITE_M1,
  input  logic [2:0]    HSIZE_M1,
  input  logic [DW-1:0] HWDATA_M1,
  output logic          HREADY_M1,
  output logic [DW-1:0] HRDATA_M1,
  // slave
  output logic [AW-1:0] HADDR,
  output logic [1:0]    HTRANS,
  output logic          HWRITE,
  output logic [2:0]    HSIZE,
  output logic [DW-1:0] HWDATA,
  input  logic [DW-1:0] HRDATA,
  input  logic          HREADY
);

  localparam logic [1:0] TRANS_SEQ = 2'b11;

  // master inputs gathered into arrays so both ports share one description
  logic [AW-1:0] in_addr_s  [2];
  logic [1:0]    in_trans_s [2];
  logic          in_write_s [2];
  logic [2:0]    in_size_s  [2];

  assign in_addr_s[0]  = HADDR_M0;
  assign in_addr_s[1]  = HADDR_M1;
  assign in_trans_s[0] = HTRANS_M0;
  assign in_trans_s[1] = HTRANS_M1;
  assign in_write_s[0] = HWRITE_M0;
  assign in_write_s[1] = HWRITE_M1;
  assign in_size_s[0]  = HSIZE_M0;
  assign in_size_s[1]  = HSIZE_M1;

  // per-master state
  logic [1:0]    hold_vld_r;
  logic [AW-1:0] hold_addr_r  [2];
  logic [1:0]    hold_trans_r [2];
  logic          hold_write_r [2];
  logic [2:0]    hold_size_r  [2];
  logic [1:0]    out_r;          // transfer in flight (held or forwarded)

  // global state
  logic          dph_vld_r;
  logic          dph_own_r;
  logic          last_gnt_r;

  // per-master combinational view
  logic [1:0]    rdy_s;
  logic [1:0]    live_s;
  logic [1:0]    cand_s;
  logic [AW-1:0] cand_addr_s  [2];
  logic [1:0]    cand_trans_s [2];
  logic          cand_write_s [2];
  logic [2:0]    cand_size_s  [2];

  logic          win_vld_s;
  logic          win_s;

  // Master-side ready, live request and candidate selection (hold wins over live).
  always_comb begin
    rdy_s  = 2'b00;
    live_s = 2'b00;
    cand_s = 2'b00;
    for (int m = 0; m < 2; m++) begin
      cand_addr_s[m]  = in_addr_s[m];
      cand_trans_s[m] = in_trans_s[m];
      cand_write_s[m] = in_write_s[m];
      cand_size_s[m]  = in_size_s[m];
      // A master in flight may only move on when its own data phase ends
      // and nothing of it is still parked in the hold register.
      if (!out_r[m]) begin
        rdy_s[m] = 1'b1;
      end else if (dph_vld_r && (dph_own_r == m[0]) && !hold_vld_r[m]) begin
        rdy_s[m] = HREADY;
      end else begin
        rdy_s[m] = 1'b0;
      end
      // Gating with HRESETn keeps every output at its reset value while reset is held.
      live_s[m] = HRESETn & in_trans_s[m][1] & rdy_s[m];
      cand_s[m] = hold_vld_r[m] | live_s[m];
      if (hold_vld_r[m]) begin
        cand_addr_s[m]  = hold_addr_r[m];
        cand_trans_s[m] = hold_trans_r[m];
        cand_write_s[m] = hold_write_r[m];
        cand_size_s[m]  = hold_size_r[m];
      end else begin
        cand_addr_s[m]  = in_addr_s[m];
        cand_trans_s[m] = in_trans_s[m];
        cand_write_s[m] = in_write_s[m];
        cand_size_s[m]  = in_size_s[m];
      end
    end
  end

  // Round-robin winner; a SEQ beat from the last grantee locks the bus to it.
  always_comb begin
    win_vld_s = 1'b0;
    win_s     = 1'b0;
    case (cand_s)
      2'b01: begin
        win_vld_s = 1'b1;
        win_s     = 1'b0;
      end
      2'b10: begin
        win_vld_s = 1'b1;
        win_s     = 1'b1;
      end
      2'b11: begin
        win_vld_s = 1'b1;
        if (cand_trans_s[last_gnt_r] == TRANS_SEQ) begin
          win_s = last_gnt_r;
        end else begin
          win_s = ~last_gnt_r;
        end
      end
      default: begin
        win_vld_s = 1'b0;
        win_s     = 1'b0;
      end
    endcase
  end

  // Slave address/control from the winner, write data from the data-phase owner.
  always_comb begin
    HADDR  = {AW{1'b0}};
    HTRANS = 2'b00;
    HWRITE = 1'b0;
    HSIZE  = 3'b000;
    HWDATA = {DW{1'b0}};
    if (win_vld_s) begin
      HADDR  = cand_addr_s[win_s];
      HTRANS = cand_trans_s[win_s];
      HWRITE = cand_write_s[win_s];
      HSIZE  = cand_size_s[win_s];
    end else begin
      HADDR  = {AW{1'b0}};
      HTRANS = 2'b00;
      HWRITE = 1'b0;
      HSIZE  = 3'b000;
    end
    if (dph_vld_r) begin
      if (dph_own_r) begin
        HWDATA = HWDATA_M1;
      end else begin
        HWDATA = HWDATA_M0;
      end
    end else begin
      HWDATA = {DW{1'b0}};
    end
  end

  assign HREADY_M0 = rdy_s[0];
  assign HREADY_M1 = rdy_s[1];
  assign HRDATA_M0 = HRDATA;
  assign HRDATA_M1 = HRDATA;

  // Hold registers, in-flight flags, data-phase ownership and round-robin pointer.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      hold_vld_r <= 2'b00;
      out_r      <= 2'b00;
      dph_vld_r  <= 1'b0;
      dph_own_r  <= 1'b0;
      last_gnt_r <= 1'b1;
      for (int m = 0; m < 2; m++) begin
        hold_addr_r[m]  <= {AW{1'b0}};
        hold_trans_r[m] <= 2'b00;
        hold_write_r[m] <= 1'b0;
        hold_size_r[m]  <= 3'b000;
      end
    end else begin
      for (int m = 0; m < 2; m++) begin
        // A live request that is not forwarded this edge (lost the slot, or
        // the slave stalled) must be captured: the master has already moved on.
        if (HREADY && win_vld_s && (win_s == m[0])) begin
          hold_vld_r[m] <= 1'b0;
        end else if (live_s[m]) begin
          hold_vld_r[m]   <= 1'b1;
          hold_addr_r[m]  <= in_addr_s[m];
          hold_trans_r[m] <= in_trans_s[m];
          hold_write_r[m] <= in_write_s[m];
          hold_size_r[m]  <= in_size_s[m];
        end
        // A back-to-back request keeps the master in flight across its completion.
        if (live_s[m]) begin
          out_r[m] <= 1'b1;
        end else if (HREADY && dph_vld_r && (dph_own_r == m[0]) && !hold_vld_r[m]) begin
          out_r[m] <= 1'b0;
        end
      end
      if (HREADY) begin
        if (win_vld_s) begin
          last_gnt_r <= win_s;
          dph_vld_r  <= 1'b1;
          dph_own_r  <= win_s;
        end else begin
          dph_vld_r  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ahbl_2m_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ahbl_2m_rr_arbiter
//
// Directed scenarios followed by a randomized run. A transaction-level model
// (per-master waiting queues, in-flight counts, data-phase owner) predicts
// every slave and master output each cycle.
// ---------------------------------------------------------------------------
module tb_ahbl_2m_rr_arbiter;

  localparam int AW = 32;
  localparam int DW = 64;

  logic          HCLK = 1'b0;
  logic          HRESETn;
  logic [AW-1:0] m_addr  [2];
  logic [1:0]    m_trans [2];
  logic          m_write [2];
  logic [2:0]    m_size  [2];
  logic [DW-1:0] m_wdata [2];
  logic          HREADY_M0, HREADY_M1;
  logic [DW-1:0] HRDATA_M0, HRDATA_M1;
  logic [AW-1:0] HADDR;
  logic [1:0]    HTRANS;
  logic          HWRITE;
  logic [2:0]    HSIZE;
  logic [DW-1:0] HWDATA;
  logic [DW-1:0] HRDATA;
  logic          HREADY;

  int n_asserts = 0;
  int n_fail    = 0;

  ahbl_2m_rr_arbiter #(.AW(AW), .DW(DW)) dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .HADDR_M0  (m_addr[0]),
    .HTRANS_M0 (m_trans[0]),
    .HWRITE_M0 (m_write[0]),
    .HSIZE_M0  (m_size[0]),
    .HWDATA_M0 (m_wdata[0]),
    .HREADY_M0 (HREADY_M0),
    .HRDATA_M0 (HRDATA_M0),
    .HADDR_M1  (m_addr[1]),
    .HTRANS_M1 (m_trans[1]),
    .HWRITE_M1 (m_write[1]),
    .HSIZE_M1  (m_size[1]),
    .HWDATA_M1 (m_wdata[1]),
    .HREADY_M1 (HREADY_M1),
    .HRDATA_M1 (HRDATA_M1),
    .HADDR     (HADDR),
    .HTRANS    (HTRANS),
    .HWRITE    (HWRITE),
    .HSIZE     (HSIZE),
    .HWDATA    (HWDATA),
    .HRDATA    (HRDATA),
    .HREADY    (HREADY)
  );

  always #5 HCLK = ~HCLK;

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [AW-1:0] addr;
    logic [1:0]    trans;
    logic          write;
    logic [2:0]    size;
  } req_t;

  req_t q [2][$];        // address phases accepted but not yet on the bus
  int   inflight [2];    // transfers accepted and not yet completed
  int   dp_owner;        // master in the slave data phase, -1 if none
  int   last_grant;
  logic exp_rdy [2];     // expected HREADY_Mx at the last evaluated edge
  logic acc [2];         // address phase of master accepted at that edge

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    q[0].delete();
    q[1].delete();
    inflight[0] = 0;
    inflight[1] = 0;
    dp_owner    = -1;
    last_grant  = 1;
    exp_rdy[0]  = 1'b1;
    exp_rdy[1]  = 1'b1;
    acc[0]      = 1'b0;
    acc[1]      = 1'b0;
  endfunction

  // Predict outputs for the current cycle, compare, then advance to the next edge.
  task automatic model_step();
    req_t r [2];
    logic c [2];
    logic live [2];
    int   w;
    for (int m = 0; m < 2; m++) begin
      exp_rdy[m] = (inflight[m] == 0) ||
                   (dp_owner == m && HREADY === 1'b1 && q[m].size() == 0);
      live[m] = m_trans[m][1] && exp_rdy[m];
      c[m]    = (q[m].size() > 0) || live[m];
      if (q[m].size() > 0) begin
        r[m] = q[m][0];
      end else begin
        r[m].addr  = m_addr[m];
        r[m].trans = m_trans[m];
        r[m].write = m_write[m];
        r[m].size  = m_size[m];
      end
    end
    w = -1;
    if (c[0] && c[1]) w = (r[last_grant].trans == 2'b11) ? last_grant : 1 - last_grant;
    else if (c[0])    w = 0;
    else if (c[1])    w = 1;

    chk("HREADY_M0", 64'(HREADY_M0), 64'(exp_rdy[0]));
    chk("HREADY_M1", 64'(HREADY_M1), 64'(exp_rdy[1]));
    if (w >= 0) begin
      chk("HTRANS", 64'(HTRANS), 64'(r[w].trans));
      chk("HADDR",  64'(HADDR),  64'(r[w].addr));
      chk("HWRITE", 64'(HWRITE), 64'(r[w].write));
      chk("HSIZE",  64'(HSIZE),  64'(r[w].size));
    end else begin
      chk("HTRANS_idle", 64'(HTRANS), 64'h0);
      chk("HADDR_idle",  64'(HADDR),  64'h0);
      chk("HWRITE_idle", 64'(HWRITE), 64'h0);
      chk("HSIZE_idle",  64'(HSIZE),  64'h0);
    end
    chk("HWDATA", HWDATA, (dp_owner >= 0) ? m_wdata[dp_owner] : 64'h0);
    chk("HRDATA_M0", HRDATA_M0, HRDATA);
    chk("HRDATA_M1", HRDATA_M1, HRDATA);

    for (int m = 0; m < 2; m++) begin
      acc[m] = live[m];
      if (live[m]) inflight[m]++;
    end
    if (HREADY === 1'b1) begin
      if (dp_owner >= 0) inflight[dp_owner]--;
      for (int m = 0; m < 2; m++)
        if (live[m] && m != w) q[m].push_back(r[m]);
      if (w >= 0) begin
        if (!live[w]) void'(q[w].pop_front());
        last_grant = w;
      end
      dp_owner = w;
    end else begin
      for (int m = 0; m < 2; m++)
        if (live[m]) q[m].push_back(r[m]);
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(negedge HCLK);
    model_step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic set_m(input int m, input logic [1:0] t, input logic [AW-1:0] a, input logic w);
    m_trans[m] = t;
    m_addr[m]  = a;
    m_write[m] = w;
    m_size[m]  = 3'd3;
  endtask

  task automatic idle_all();
    set_m(0, 2'b00, 32'h0, 1'b0);
    set_m(1, 2'b00, 32'h0, 1'b0);
  endtask

  // Assert reset (masters left as they are), check async reset values, release.
  task automatic do_reset();
    HRESETn = 1'b0;
    #1;
    chk("rst_htrans",    64'(HTRANS),    64'h0);
    chk("rst_haddr",     64'(HADDR),     64'h0);
    chk("rst_hwrite",    64'(HWRITE),    64'h0);
    chk("rst_hsize",     64'(HSIZE),     64'h0);
    chk("rst_hwdata",    HWDATA,         64'h0);
    chk("rst_hready_m0", 64'(HREADY_M0), 64'h1);
    chk("rst_hready_m1", 64'(HREADY_M1), 64'h1);
    idle_all();
    HREADY = 1'b1;
    HRDATA = 64'h0;
    repeat (2) @(posedge HCLK);
    #2;
    HRESETn = 1'b1;
    model_reset();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int beats [2];
    logic [AW-1:0] exp_a;
    logic [1:0]    exp_t;

    HRESETn    = 1'b1;
    HREADY     = 1'b1;
    HRDATA     = 64'h0;
    m_wdata[0] = 64'h0;
    m_wdata[1] = 64'h0;
    idle_all();
    model_reset();
    #1;
    do_reset();

    // 1: single M0 NONSEQ read
    set_m(0, 2'b10, 32'h100, 1'b0);
    #1;
    chk("t1_htrans",    64'(HTRANS),    64'h2);
    chk("t1_haddr",     64'(HADDR),     64'h100);
    chk("t1_hready_m1", 64'(HREADY_M1), 64'h1);
    tick();
    set_m(0, 2'b00, 32'h0, 1'b0);
    HRDATA = 64'hDEAD_BEEF_0123_4567;
    #1;
    chk("t1_hrdata_m0", HRDATA_M0, 64'hDEAD_BEEF_0123_4567);
    chk("t1_hready_m0", 64'(HREADY_M0), 64'h1);
    chk("t1_hready_m1b", 64'(HREADY_M1), 64'h1);
    chk("t1_htrans_idle", 64'(HTRANS), 64'h0);
    tick();

    // 2: simultaneous NONSEQ after reset, M1 captured then forwarded
    do_reset();
    set_m(0, 2'b10, 32'h0, 1'b0);
    set_m(1, 2'b10, 32'h2000, 1'b1);
    m_wdata[1] = 64'hA5;
    #1;
    chk("t2_c0_haddr",  64'(HADDR),  64'h0);
    chk("t2_c0_hwrite", 64'(HWRITE), 64'h0);
    tick();
    idle_all();
    #1;
    chk("t2_c1_haddr",     64'(HADDR),     64'h2000);
    chk("t2_c1_hwrite",    64'(HWRITE),    64'h1);
    chk("t2_c1_hready_m1", 64'(HREADY_M1), 64'h0);
    tick();
    #1;
    chk("t2_c2_hwdata",    HWDATA,         64'hA5);
    chk("t2_c2_hready_m1", 64'(HREADY_M1), 64'h1);
    tick();

    // 3: continuous NONSEQ from both, grants alternate with no bubbles
    do_reset();
    set_m(0, 2'b10, 32'h1000, 1'b0);
    set_m(1, 2'b10, 32'h3000, 1'b0);
    for (int i = 0; i < 8; i++) begin
      #1;
      exp_a = ((i % 2 == 0) ? 32'h1000 : 32'h3000) + 32'(8 * (i / 2));
      chk("t3_htrans", 64'(HTRANS), 64'h2);
      chk("t3_haddr",  64'(HADDR),  64'(exp_a));
      tick();
      for (int m = 0; m < 2; m++)
        if (acc[m]) m_addr[m] = m_addr[m] + 32'h8;
    end
    idle_all();
    repeat (3) tick();

    // 4: three wait states on M0 while M1 requests
    do_reset();
    set_m(0, 2'b10, 32'h400, 1'b0);
    #1;
    chk("t4_haddr_m0", 64'(HADDR), 64'h400);
    tick();
    HREADY = 1'b0;
    set_m(0, 2'b10, 32'h408, 1'b0);
    set_m(1, 2'b10, 32'h5000, 1'b0);
    #1;
    chk("t4_hready_m0_wait", 64'(HREADY_M0), 64'h0);
    tick();
    set_m(1, 2'b00, 32'h0, 1'b0);
    #1;
    chk("t4_hready_m1_held", 64'(HREADY_M1), 64'h0);
    tick();
    tick();
    HREADY = 1'b1;
    #1;
    chk("t4_haddr_m1", 64'(HADDR),  64'h5000);
    chk("t4_htrans_m1", 64'(HTRANS), 64'h2);
    tick();
    set_m(0, 2'b00, 32'h0, 1'b0);
    #1;
    chk("t4_haddr_m0_next", 64'(HADDR), 64'h408);
    repeat (2) tick();

    // 5: M1 INCR4 burst is not interrupted by M0
    do_reset();
    for (int b = 0; b < 5; b++) begin
      if (b < 4) set_m(1, (b == 0) ? 2'b10 : 2'b11, 32'h8000 + 32'(8 * b), 1'b0);
      else       set_m(1, 2'b00, 32'h0, 1'b0);
      if (b == 1) set_m(0, 2'b10, 32'h600, 1'b0);
      if (b == 2) set_m(0, 2'b00, 32'h0, 1'b0);
      exp_a = (b < 4) ? 32'h8000 + 32'(8 * b) : 32'h600;
      exp_t = (b == 0 || b == 4) ? 2'b10 : 2'b11;
      #1;
      chk("t5_haddr",  64'(HADDR),  64'(exp_a));
      chk("t5_htrans", 64'(HTRANS), 64'(exp_t));
      tick();
    end
    repeat (2) tick();

    // 6: reset while M1 held and M0 in its data phase
    do_reset();
    set_m(0, 2'b10, 32'h700, 1'b0);
    set_m(1, 2'b10, 32'h9000, 1'b1);
    tick();
    HREADY = 1'b0;
    set_m(0, 2'b10, 32'h708, 1'b0);
    set_m(1, 2'b00, 32'h0, 1'b0);
    #1;
    chk("t6_pre_hready_m1", 64'(HREADY_M1), 64'h0);
    do_reset();
    set_m(1, 2'b10, 32'h9100, 1'b0);
    #1;
    chk("t6_haddr",  64'(HADDR),  64'h9100);
    chk("t6_htrans", 64'(HTRANS), 64'h2);
    tick();
    set_m(1, 2'b00, 32'h0, 1'b0);
    #1;
    chk("t6_hready_m1", 64'(HREADY_M1), 64'h1);
    tick();

    // 7: randomized traffic with random slave wait states
    do_reset();
    beats[0] = 0;
    beats[1] = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int m = 0; m < 2; m++) begin
        if (exp_rdy[m]) begin
          if (beats[m] > 0) begin
            m_trans[m] = 2'b11;
            m_addr[m]  = m_addr[m] + 32'h8;
            beats[m]--;
          end else begin
            case ($urandom_range(0, 9))
              0, 1, 2, 3, 4, 5: begin
                m_trans[m] = 2'b10;
                m_addr[m]  = $urandom;
                m_write[m] = 1'($urandom_range(0, 1));
                m_size[m]  = 3'($urandom_range(0, 7));
                beats[m]   = ($urandom_range(0, 1) == 1) ? 3 : 0;
              end
              6:       m_trans[m] = 2'b01;
              default: m_trans[m] = 2'b00;
            endcase
          end
        end
        m_wdata[m] = {$urandom, $urandom};
      end
      HREADY = ($urandom_range(0, 3) != 0);
      HRDATA = {$urandom, $urandom};
      tick();
    end
    HREADY = 1'b1;
    idle_all();
    repeat (4) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
